// File: rtl/mwadd_pkg.sv
// Shared definitions for the multi-word sequential adder.
package mwadd_pkg;

    localparam int SLICE_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mwadd_state_e;

endpackage

// File: rtl/parallel_adder_16bit.sv
// 16-bit combinational slice adder with carry in and carry out.
module parallel_adder_16bit (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);

    logic [16:0] w_full;

    // Widen by one bit so the carry-out falls out of the add.
    assign w_full = {1'b0, a} + {1'b0, b} + {16'b0, cin};
    assign sum    = w_full[15:0];
    assign cout   = w_full[16];

endmodule

// File: rtl/multiword_add_seq.sv
// Multi-word sequential adder: adds two WORDS*16-bit operands one 16-bit
// slice per cycle through a single parallel_adder_16bit, LSB slice first.
// Optional feature macro: MWADD_OVF_EN adds the signed-overflow output ovf.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for an operand bundle, in_ready high
// RUN   | one slice added per cycle, carry chained through r_carry
// DONE  | result held on sum/cout with out_valid until out_ready
module multiword_add_seq
    import mwadd_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WORDS*SLICE_W-1:0]   a,
    input  logic [WORDS*SLICE_W-1:0]   b,
    input  logic                       cin,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WORDS*SLICE_W-1:0]   sum,
    output logic                       cout,
`ifdef MWADD_OVF_EN
    output logic                       ovf,
`endif
    output logic                       busy
);

    localparam int W     = WORDS * SLICE_W;
    localparam int IDX_W = $clog2(WORDS) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    mwadd_state_e       r_state;
    mwadd_state_e       w_state_next;
    logic [IDX_W-1:0]   r_idx;
    logic [W-1:0]       r_a;
    logic [W-1:0]       r_b;
    logic [W-1:0]       r_sum;
    logic               r_carry;
    logic               r_cout;
    logic [SLICE_W-1:0] w_a_slice;
    logic [SLICE_W-1:0] w_b_slice;
    logic [SLICE_W-1:0] w_slice_sum;
    logic               w_slice_cout;
    logic               w_accept;
    logic               w_last;
`ifdef MWADD_OVF_EN
    logic               r_ovf;
    logic               w_msb_cin;
`endif

    // in_ready is masked during reset so nothing reads as ready until rst drops.
    assign in_ready  = (r_state == IDLE) && !rst;
    assign w_accept  = in_valid && in_ready;
    assign w_last    = (r_idx == LAST_IDX);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state != IDLE);
    assign sum       = r_sum;
    assign cout      = r_cout;

    assign w_a_slice = r_a[r_idx*SLICE_W +: SLICE_W];
    assign w_b_slice = r_b[r_idx*SLICE_W +: SLICE_W];

    parallel_adder_16bit u_slice_adder (
        .a    (w_a_slice),
        .b    (w_b_slice),
        .cin  (r_carry),
        .sum  (w_slice_sum),
        .cout (w_slice_cout)
    );

`ifdef MWADD_OVF_EN
    // Carry into bit 15 recovered from the slice's own operands and result.
    assign w_msb_cin = w_a_slice[SLICE_W-1] ^ w_b_slice[SLICE_W-1] ^ w_slice_sum[SLICE_W-1];
    assign ovf       = r_ovf;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    // Next-state decode.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (w_accept)  w_state_next = RUN;
            RUN:     if (w_last)    w_state_next = DONE;
            DONE:    if (out_ready) w_state_next = IDLE;
            default:                w_state_next = IDLE;
        endcase
    end

    // Operand capture, slice-by-slice accumulation and final carry registration.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
`ifdef MWADD_OVF_EN
            r_ovf   <= 1'b0;
`endif
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= cin;
                        r_idx   <= '0;
                    end
                end
                RUN: begin
                    r_sum[r_idx*SLICE_W +: SLICE_W] <= w_slice_sum;
                    r_carry <= w_slice_cout;
                    r_idx   <= r_idx + 1'b1;
                    if (w_last) begin
                        r_cout <= w_slice_cout;
`ifdef MWADD_OVF_EN
                        r_ovf  <= w_msb_cin ^ w_slice_cout;
`endif
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
